cordic_engine: RTL and testbench

//  Parametrised iterative CORDIC engine for the FFT accelerator (twiddle rotation and magnitude/phase).
//  Two modes: ROTATION rotates (xstart,ystart) by zangle; VECTORING drives y to 0, returns magnitude and angle.

---
 rtl/cordic_pkg.sv | 29 ++
 rtl/cordic_atan_rom.sv | 18 +
 rtl/cordic_engine.sv | 147 ++++++++++++++
 tb/tb_cordic_engine.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_pkg.sv
// Shared constants for the iterative CORDIC engine: arctangent table, mode codes,
// FSM encoding and the unscaled CORDIC gain.
package cordic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_HOLD = 2'd2
  } cordic_state_e;

  localparam logic MODE_ROT = 1'b0;
  localparam logic MODE_VEC = 1'b1;

  // Asymptotic gain of the micro-rotation sequence; results are not divided by it.
  localparam real CORDIC_K = 1.6467602581210656;

  // atan(2^-i) in units of 2^-32 turn, rounded to nearest.
  localparam logic [31:0] ATAN_TABLE [0:31] = '{
    32'h2000_0000, 32'h12E4_051E, 32'h09FB_385B, 32'h0511_11D4,
    32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
    32'h0028_BE53, 32'h0014_5F2F, 32'h000A_2F98, 32'h0005_17CC,
    32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2FA, 32'h0000_517D,
    32'h0000_28BE, 32'h0000_145F, 32'h0000_0A30, 32'h0000_0518,
    32'h0000_028C, 32'h0000_0146, 32'h0000_00A3, 32'h0000_0051,
    32'h0000_0029, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
    32'h0000_0003, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000
  };

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup, rescaled from the 32-bit full-turn table to Z_W bits
// with round-to-nearest.
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int Z_W   = 32,
  parameter int IDX_W = 5
) (
  input  logic [IDX_W-1:0] i_idx,
  output logic [Z_W-1:0]   o_atan
);

  localparam int          SH  = 32 - Z_W;
  localparam logic [32:0] RND = (33'd1 << SH) >> 1;

  assign o_atan = Z_W'(({1'b0, ATAN_TABLE[i_idx]} + RND) >> SH);

endmodule

// File: rtl/cordic_engine.sv
// Iterative CORDIC: quadrant pre-rotation on accept, one micro-rotation per cycle,
// then a saturating output register held under a valid/ready handshake.
module cordic_engine
  import cordic_pkg::*;
#(
  parameter int XY_W = 16,
  parameter int Z_W  = 32,
  parameter int ITER = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   mode,
  input  logic signed [XY_W-1:0] xstart,
  input  logic signed [XY_W-1:0] ystart,
  input  logic [Z_W-1:0]         zangle,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [XY_W-1:0] xout,
  output logic signed [XY_W-1:0] yout,
  output logic [Z_W-1:0]         zout,
  output logic                   done
);

  localparam int IW    = XY_W + 2;
  localparam int CNT_W = $clog2(ITER + 1);

  cordic_state_e r_state, w_state_nxt;

  logic [CNT_W-1:0]       r_i;
  logic                   r_mode;
  logic signed [IW-1:0]   r_x, r_y;
  logic [Z_W-1:0]         r_z;
  logic signed [XY_W-1:0] r_xout, r_yout;
  logic [Z_W-1:0]         r_zout;

  logic signed [IW-1:0]   w_x_ext, w_y_ext, w_x_pre, w_y_pre, w_x_sh, w_y_sh;
  logic [Z_W-1:0]         w_z_pre, w_atan;
  logic                   w_neg, w_accept, w_last, w_d_pos;

  function automatic logic signed [XY_W-1:0] sat_xy(input logic signed [IW-1:0] v);
    logic [2:0] top;
    top = v[IW-1:XY_W-1];
    if ((&top) || (~|top))
      return v[XY_W-1:0];
    else if (v[IW-1])
      return {1'b1, {(XY_W-1){1'b0}}};
    else
      return {1'b0, {(XY_W-1){1'b1}}};
  endfunction

  assign in_ready  = !reset && (r_state == ST_IDLE);
  assign out_valid = !reset && (r_state == ST_HOLD);
  assign done      = out_valid && out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_last    = (r_i == CNT_W'(ITER));

  assign xout = r_xout;
  assign yout = r_yout;
  assign zout = r_zout;

  // Pre-rotation folds the operand into the right half-plane so the +-99.9 deg
  // convergence range of the micro-rotations covers the full circle.
  assign w_x_ext = {{2{xstart[XY_W-1]}}, xstart};
  assign w_y_ext = {{2{ystart[XY_W-1]}}, ystart};

  always_comb begin
    w_neg   = 1'b0;
    w_z_pre = zangle;
    if (mode == MODE_VEC) begin
      w_neg   = xstart[XY_W-1];
      w_z_pre = w_neg ? {1'b1, {(Z_W-1){1'b0}}} : '0;
    end else begin
      w_neg   = zangle[Z_W-1] ^ zangle[Z_W-2];
      w_z_pre = w_neg ? {~zangle[Z_W-1], zangle[Z_W-2:0]} : zangle;
    end
    w_x_pre = w_neg ? -w_x_ext : w_x_ext;
    w_y_pre = w_neg ? -w_y_ext : w_y_ext;
  end

  cordic_atan_rom #(
    .Z_W   (Z_W),
    .IDX_W (CNT_W)
  ) u_atan_rom (
    .i_idx  (r_i),
    .o_atan (w_atan)
  );

  assign w_x_sh  = r_x >>> r_i;
  assign w_y_sh  = r_y >>> r_i;
  assign w_d_pos = (r_mode == MODE_ROT) ? ~r_z[Z_W-1] : r_y[IW-1];

  // Datapath registers: loaded on accept, then one micro-rotation per ITER cycle.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_x    <= w_x_pre;
      r_y    <= w_y_pre;
      r_z    <= w_z_pre;
      r_mode <= mode;
    end else if ((r_state == ST_ITER) && !w_last) begin
      if (w_d_pos) begin
        r_x <= r_x - w_y_sh;
        r_y <= r_y + w_x_sh;
        r_z <= r_z - w_atan;
      end else begin
        r_x <= r_x + w_y_sh;
        r_y <= r_y - w_x_sh;
        r_z <= r_z + w_atan;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)  w_state_nxt = ST_ITER;
      ST_ITER: if (w_last)    w_state_nxt = ST_HOLD;
      ST_HOLD: if (out_ready) w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  // Control and output registers; the extra ITER cycle with r_i == ITER is the
  // saturation stage feeding the held result.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_i     <= '0;
      r_xout  <= '0;
      r_yout  <= '0;
      r_zout  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept)
        r_i <= '0;
      else if ((r_state == ST_ITER) && !w_last)
        r_i <= r_i + 1'b1;
      if ((r_state == ST_ITER) && w_last) begin
        r_xout <= sat_xy(r_x);
        r_yout <= sat_xy(r_y);
        r_zout <= r_z;
      end
    end
  end

endmodule

// File: tb/tb_cordic_engine.sv
// Directed and randomized checks of cordic_engine against a floating-point
// rotation / polar-conversion reference.
module tb_cordic_engine;
  import cordic_pkg::*;

  localparam int XY_W    = 16;
  localparam int Z_W     = 32;
  localparam int ITER    = 16;
  localparam int TOL_XY  = 4;
  localparam int TOL_RND = 8;
  localparam int TOL_Z   = 1 << 18;
  localparam real PI     = 3.14159265358979323846;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic mode = 1'b0;
  logic out_ready = 1'b1;
  logic signed [XY_W-1:0] xstart = '0;
  logic signed [XY_W-1:0] ystart = '0;
  logic [Z_W-1:0] zangle = '0;
  logic in_ready, out_valid, done;
  logic signed [XY_W-1:0] xout, yout;
  logic [Z_W-1:0] zout;

  int  n_chk  = 0;
  int  n_fail = 0;
  real k_gain;

  cordic_engine #(.XY_W(XY_W), .Z_W(Z_W), .ITER(ITER)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .xstart    (xstart),
    .ystart    (ystart),
    .zangle    (zangle),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .xout      (xout),
    .yout      (yout),
    .zout      (zout),
    .done      (done)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp, input int tol);
    int diff;
    diff = obs - exp;
    if (diff < 0) diff = -diff;
    n_chk++;
    assert ((diff <= tol) === 1'b1) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  task automatic chk_z(input string tag, input logic [31:0] obs, input logic [31:0] exp, input int tol);
    int diff;
    diff = int'(obs - exp);
    if (diff < 0) diff = -diff;
    n_chk++;
    assert ((diff <= tol) === 1'b1) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  function automatic int clip(input real v);
    longint r;
    r = longint'(v);
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return int'(r);
  endfunction

  // Ideal result: gain-scaled rotation by the full angle, or gain-scaled polar form.
  task automatic model(input logic m, input int x, input int y, input logic [31:0] z,
                       output int ex, output int ey, output logic [31:0] ez);
    real th, xr, yr;
    xr = real'(x);
    yr = real'(y);
    if (m == MODE_ROT) begin
      th = real'($signed(z)) / 4294967296.0 * 2.0 * PI;
      ex = clip(k_gain * (xr * $cos(th) - yr * $sin(th)));
      ey = clip(k_gain * (xr * $sin(th) + yr * $cos(th)));
      ez = '0;
    end else begin
      ex = clip(k_gain * $sqrt(xr * xr + yr * yr));
      ey = 0;
      ez = 32'(longint'($atan2(yr, xr) / (2.0 * PI) * 4294967296.0));
    end
  endtask

  // Starts one operation and returns at the negedge where out_valid is first seen.
  task automatic run_op(input logic m, input int x, input int y, input logic [31:0] z,
                        output int ox, output int oy, output logic [31:0] oz, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clock);
      guard++;
    end
    chk("in_ready_before_op", int'(in_ready), 1, 0);
    mode     = m;
    xstart   = 16'(x);
    ystart   = 16'(y);
    zangle   = z;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    mode     = ~m;
    xstart   = ~xstart;
    ystart   = ~ystart;
    zangle   = ~zangle;
    lat = 0;
    while (lat < 100) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
      if (out_valid) break;
    end
    ox = int'(xout);
    oy = int'(yout);
    oz = zout;
  endtask

  task automatic finish_ok(input string tag);
    chk({tag, "_done_pulse"}, int'(done), 1, 0);
    @(posedge clock);
    @(negedge clock);
    chk({tag, "_valid_drop"}, int'(out_valid), 0, 0);
    chk({tag, "_done_drop"}, int'(done), 0, 0);
    chk({tag, "_ready_back"}, int'(in_ready), 1, 0);
  endtask

  initial begin
    int ox, oy, lat, ex, ey, x, y, seen_v, seen_d;
    logic [31:0] oz, ez, z;
    int hx, hy;
    logic [31:0] hz;

    k_gain = 1.0;
    for (int i = 0; i < ITER; i++) k_gain = k_gain * $sqrt(1.0 + 2.0 ** (-2.0 * i));

    // Reset held for three cycles
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk("rst_in_ready", int'(in_ready), 0, 0);
      chk("rst_out_valid", int'(out_valid), 0, 0);
      chk("rst_done", int'(done), 0, 0);
    end
    chk("rst_xout", int'(xout), 0, 0);
    chk("rst_zout", int'(zout), 0, 0);
    reset = 1'b0;
    #1;
    chk("rst_release_in_ready", int'(in_ready), 1, 0);

    // 45 degree rotation
    run_op(MODE_ROT, 19000, 0, 32'h2000_0000, ox, oy, oz, lat);
    chk("rot45_latency", lat, ITER + 1, 0);
    chk("rot45_x", ox, 22125, TOL_XY);
    chk("rot45_y", oy, 22125, TOL_XY);
    chk_z("rot45_z", oz, 32'h0, TOL_Z);
    finish_ok("rot45");

    // ~165 degrees: needs the 180 degree pre-rotation
    run_op(MODE_ROT, 19000, 0, 32'h7555_5555, ox, oy, oz, lat);
    chk("rot165_x", ox, -30223, TOL_XY);
    chk("rot165_y", oy, 8098, TOL_XY);
    chk_z("rot165_z", oz, 32'h0, TOL_Z);
    finish_ok("rot165");

    // Vectoring from the second quadrant
    run_op(MODE_VEC, -10000, 10000, 32'h1234_5678, ox, oy, oz, lat);
    chk("vec135_latency", lat, ITER + 1, 0);
    chk("vec135_x", ox, 23290, TOL_XY);
    chk("vec135_y", oy, 0, TOL_XY);
    chk_z("vec135_z", oz, 32'h6000_0000, TOL_Z);
    finish_ok("vec135");

    // Saturation, including negation of the most negative operand
    run_op(MODE_ROT, 32000, 0, 32'h0, ox, oy, oz, lat);
    chk("sat_pos_x", ox, 32767, 0);
    chk("sat_pos_y", oy, 0, TOL_XY);
    finish_ok("sat_pos");
    run_op(MODE_ROT, -32768, 0, 32'h8000_0000, ox, oy, oz, lat);
    chk("sat_neg_x", ox, 32767, 0);
    chk("sat_neg_y", oy, 0, TOL_XY);
    finish_ok("sat_neg");

    // Random rotations against the reference
    for (int t = 0; t < 20; t++) begin
      x = int'($urandom_range(24000, 0)) - 12000;
      y = int'($urandom_range(24000, 0)) - 12000;
      z = $urandom;
      model(MODE_ROT, x, y, z, ex, ey, ez);
      run_op(MODE_ROT, x, y, z, ox, oy, oz, lat);
      chk("rand_rot_latency", lat, ITER + 1, 0);
      chk("rand_rot_x", ox, ex, TOL_RND);
      chk("rand_rot_y", oy, ey, TOL_RND);
      chk_z("rand_rot_z", oz, ez, TOL_Z);
      finish_ok("rand_rot");
    end

    // Random vectoring, magnitude kept large enough for a tight angle check
    for (int t = 0; t < 12; t++) begin
      x = 0;
      y = 0;
      for (int g = 0; g < 100 && (x * x + y * y) < 64000000; g++) begin
        x = int'($urandom_range(24000, 0)) - 12000;
        y = int'($urandom_range(24000, 0)) - 12000;
      end
      model(MODE_VEC, x, y, 32'h0, ex, ey, ez);
      run_op(MODE_VEC, x, y, $urandom, ox, oy, oz, lat);
      chk("rand_vec_x", ox, ex, TOL_RND);
      chk("rand_vec_y", oy, ey, TOL_RND);
      chk_z("rand_vec_z", oz, ez, TOL_Z);
      finish_ok("rand_vec");
    end

    // Backpressure: result held while out_ready is low, new operands ignored
    out_ready = 1'b0;
    model(MODE_ROT, 10000, -5000, 32'h1555_5555, ex, ey, ez);
    run_op(MODE_ROT, 10000, -5000, 32'h1555_5555, hx, hy, hz, lat);
    chk("bp_latency", lat, ITER + 1, 0);
    chk("bp_x", hx, ex, TOL_RND);
    chk("bp_y", hy, ey, TOL_RND);
    mode     = MODE_VEC;
    xstart   = 16'sd1234;
    ystart   = -16'sd4321;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clock);
      @(negedge clock);
      chk("bp_hold_valid", int'(out_valid), 1, 0);
      chk("bp_hold_ready", int'(in_ready), 0, 0);
      chk("bp_hold_done", int'(done), 0, 0);
      chk("bp_hold_x", int'(xout), hx, 0);
      chk("bp_hold_y", int'(yout), hy, 0);
      chk_z("bp_hold_z", zout, hz, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    finish_ok("bp");
    seen_v = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clock);
      if (out_valid) seen_v = 1;
    end
    chk("bp_nothing_queued", seen_v, 0, 0);
    chk("bp_idle_ready", int'(in_ready), 1, 0);

    // Abort by reset in the eighth iteration cycle
    mode     = MODE_ROT;
    xstart   = 16'sd15000;
    ystart   = 16'sd0;
    zangle   = 32'h1000_0000;
    in_valid = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("abort_ready_in_reset", int'(in_ready), 0, 0);
    chk("abort_valid_in_reset", int'(out_valid), 0, 0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("abort_ready_after", int'(in_ready), 1, 0);
    seen_v = 0;
    seen_d = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clock);
      if (out_valid) seen_v = 1;
      if (done) seen_d = 1;
    end
    chk("abort_no_valid", seen_v, 0, 0);
    chk("abort_no_done", seen_d, 0, 0);

    // Recovery after the abort
    model(MODE_VEC, 6000, 8000, 32'h0, ex, ey, ez);
    run_op(MODE_VEC, 6000, 8000, 32'h0, ox, oy, oz, lat);
    chk("recover_latency", lat, ITER + 1, 0);
    chk("recover_x", ox, ex, TOL_RND);
    chk_z("recover_z", oz, ez, TOL_Z);
    finish_ok("recover");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
